pipelined_nand_nor_tree: RTL and testbench
==========================================

Name: pipelined_nand_nor_tree

Overview:
- Parametrised successor to the fixed four-input mixed NAND/NOR AND.
- Reduces a WIDTH-bit input vector to one bit, AND or OR selectable per sample.
- Combinational levels are built from the team's existing switch-level two-input NAND/NOR cells, with optional pipeline registers between levels.
- Used as a wide-match / all-ready / any-ready detector in clocked datapaths.

Parameters:
- WIDTH, 8, number of input bits; legal 2..64.
- PIPE, 1, 1 = register after every tree level; 0 = single output register only.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  pipeline advance enable; 0 freezes every stage.
- in_valid  input  1  a/mode sample is valid this cycle.
- mode  input  1  0 = AND reduction, 1 = OR reduction.
- a  input  WIDTH  operand vector.
- out_valid  output  1  f carries a valid result.
- f  output  1  reduction result.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Levels: L = ceil(log2(WIDTH)).
  - Level k pairs adjacent bits; an odd leftover bit is padded with the identity (1 in AND mode, 0 in OR mode).
  - Padding is applied at every level, in the polarity valid at that level.
- Polarity alternates per level:
  - AND mode: level 0 = NAND, level 1 = NOR, level 2 = NAND, and so on.
  - OR mode: level 0 = NOR, level 1 = NAND, and so on.
  - If L is odd, one final inversion restores true polarity before the output register.
- Function:
  - mode=0: f = &a.
  - mode=1: f = |a.
  - f must never come out inverted.
- PIPE=1:
  - A register stage follows each level.
  - Latency is L cycles from sample to out_valid/f.
- PIPE=0:
  - Whole tree is combinational into one output register.
  - Latency is 1 cycle.
- mode and in_valid travel down the pipeline with their data. Each stage's result uses the mode it was issued with; changing mode mid-stream never corrupts in-flight samples.
- Throughput: one sample per cycle while en=1. Back-to-back samples need no bubbles.
- en=0: all stage registers, valid bits and outputs hold their current values. Inputs presented that cycle are ignored.
- in_valid=0 with en=1: a bubble propagates; out_valid=0 when it reaches the output. f for a bubble is don't-care, but holds its previous value.
- Reset:
  - rst=1 at a clock edge clears every stage register, every valid bit, out_valid=0 and f=0.
  - Reset dominates en.
  - Reset mid-operation discards all in-flight samples. First valid output after reset release appears exactly latency cycles after the first accepted sample.
- Edge cases:
  - WIDTH=2 gives L=1: a single NAND/NOR stage plus inversion.
  - Non-power-of-two WIDTH is legal via padding.
- Elaboration must fail (error) for WIDTH<2 or WIDTH>64.

Optional Feature:
- Macro: NAND_NOR_TREE_HITCNT_EN.
- Defined:
  - Adds output hit_cnt [15:0].
  - Increments by 1 on each cycle with en=1, out_valid=1 and f=1.
  - Saturates at 16'hFFFF; never wraps.
  - Cleared to 0 by rst.
  - Updates on the same edge f is registered, so it is visible the cycle after the hit.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, PIPE=1, mode=0, en=1:
  - a=8'hFF, in_valid=1 at cycle 0 -> out_valid=1, f=1 at cycle 3.
  - a=8'hFE next cycle -> f=0 at cycle 4.
- WIDTH=8, mode=1:
  - a=8'h00 -> f=0.
  - a=8'h80 -> f=1.
  - Alternate mode every cycle with a=8'h01 -> f sequence 0,1,0,1 (AND,OR,AND,OR), latency 3, no bubbles.
- WIDTH=5 (L=3, odd, padded), PIPE=1:
  - a=5'h1F mode 0 -> f=1.
  - a=5'h0F mode 0 -> f=0.
  - a=5'h10 mode 1 -> f=1.
  - All at latency 3.
- PIPE=0, WIDTH=64:
  - a=all ones mode 0 -> f=1 one cycle later.
  - Single zero at bit 37 -> f=0.
- Stall and reset:
  - Issue 3 samples, drop en for 4 cycles -> outputs frozen, then resume in order.
  - Assert rst with 2 samples in flight -> out_valid=0, f=0 next edge; in-flight samples never emerge.
- With NAND_NOR_TREE_HITCNT_EN:
  - 5 AND hits plus 2 misses -> hit_cnt=5.
  - Preload via 65540 hits -> hit_cnt=16'hFFFF.
  - rst -> 0.

Source files
------------

// File: rtl/pipelined_nand_nor_tree.sv
// Purpose: WIDTH-bit AND/OR reduction tree built from alternating NAND/NOR cell levels.
// Latency: PIPE=1 -> ceil(log2(WIDTH)) cycles, PIPE=0 -> 1 cycle; one sample per cycle.
// Backpressure: en=0 freezes every stage and output; inputs that cycle are ignored.
// Optional feature macro NAND_NOR_TREE_HITCNT_EN adds a saturating 16-bit hit_cnt output.

// Two-input NAND leaf cell.
module nand2_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// Two-input NOR leaf cell.
module nor2_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a | b);
endmodule

// One tree node: picks NAND or NOR behaviour for the polarity of its level.
module nand_nor_cell (
  input  logic a,
  input  logic b,
  input  logic sel_nor,
  output logic y
);
  logic y_nand;
  logic y_nor;

  nand2_cell u_nand (.a(a), .b(b), .y(y_nand));
  nor2_cell  u_nor  (.a(a), .b(b), .y(y_nor));

  assign y = sel_nor ? y_nor : y_nand;
endmodule

module pipelined_nand_nor_tree #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic             f
`ifdef NAND_NOR_TREE_HITCNT_EN
  ,
  output logic [15:0]      hit_cnt
`endif
);

  // Number of tree levels; each level halves the vector (rounded up).
  localparam int L = $clog2(WIDTH);
  // Data leaving an odd number of inverting levels is complemented.
  localparam bit FINAL_INV = (L % 2) == 1;

  // Width of the vector entering level k.
  function automatic int lvl_width(input int k);
    return (WIDTH + (1 << k) - 1) >> k;
  endfunction

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("pipelined_nand_nor_tree: WIDTH must be in 2..64");
  end
  if (PIPE != 0 && PIPE != 1) begin : g_bad_pipe
    $error("pipelined_nand_nor_tree: PIPE must be 0 or 1");
  end

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int NI = lvl_width(k);
    localparam int NO = lvl_width(k + 1);
    // Inputs of odd levels arrive complemented by the level before.
    localparam bit INV_IN = (k % 2) == 1;

    logic [NI-1:0] din;
    logic          lmode;
    logic          lvalid;
    logic [NO-1:0] dout;
    logic          use_nor;
    logic          pad;

    if (k == 0) begin : g_src
      assign din    = a;
      assign lmode  = mode;
      assign lvalid = in_valid;
    end else if (PIPE != 0) begin : g_src
      // Stage register between level k-1 and level k; mode/valid travel with data.
      always_ff @(posedge clk) begin
        if (rst) begin
          din    <= '0;
          lmode  <= 1'b0;
          lvalid <= 1'b0;
        end else if (en) begin
          din    <= g_lvl[k-1].dout;
          lmode  <= g_lvl[k-1].lmode;
          lvalid <= g_lvl[k-1].lvalid;
        end
      end
    end else begin : g_src
      assign din    = g_lvl[k-1].dout;
      assign lmode  = g_lvl[k-1].lmode;
      assign lvalid = g_lvl[k-1].lvalid;
    end

    // AND mode starts with NAND, OR mode with NOR; the choice flips every level.
    assign use_nor = lmode ^ INV_IN;
    // Identity for a lone bit: true-polarity 1 (AND) / 0 (OR), complemented on odd levels.
    assign pad     = INV_IN ? lmode : ~lmode;

    for (genvar j = 0; j < NO; j++) begin : g_node
      if (2 * j + 1 < NI) begin : g_pair
        nand_nor_cell u_cell (
          .a      (din[2*j]),
          .b      (din[2*j+1]),
          .sel_nor(use_nor),
          .y      (dout[j])
        );
      end else begin : g_pad
        nand_nor_cell u_cell (
          .a      (din[2*j]),
          .b      (pad),
          .sel_nor(use_nor),
          .y      (dout[j])
        );
      end
    end
  end

  logic tree_v;
  logic tree_f;

  assign tree_v = g_lvl[L-1].lvalid;
  assign tree_f = g_lvl[L-1].dout[0] ^ FINAL_INV;

  // Output register: f only updates for valid samples so bubbles leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      f         <= 1'b0;
    end else if (en) begin
      out_valid <= tree_v;
      if (tree_v) begin
        f <= tree_f;
      end
    end
  end

`ifdef NAND_NOR_TREE_HITCNT_EN
  // Saturating count of valid true results, updated alongside f.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (en && tree_v && tree_f && (hit_cnt != 16'hFFFF)) begin
      hit_cnt <= hit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_nand_nor_tree.sv
// Purpose: scoreboard bench for three tree configurations (8/PIPE1, 5/PIPE1, 64/PIPE0).
// Latency: expected results carry the advance-edge index at which they must emerge.
// Backpressure: en is shared; stalled edges do not advance the scoreboard.
module tb_pipelined_nand_nor_tree;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en;
  logic [7:0]    a8;
  logic [4:0]    a5;
  logic [63:0]   a64;
  logic [ND-1:0] iv;
  logic [ND-1:0] md;
  logic [ND-1:0] ov;
  logic [ND-1:0] fo;
`ifdef NAND_NOR_TREE_HITCNT_EN
  logic [15:0]   hc [ND];
`endif

  pipelined_nand_nor_tree #(.WIDTH(8), .PIPE(1)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv[0]), .mode(md[0]), .a(a8),
    .out_valid(ov[0]), .f(fo[0])
`ifdef NAND_NOR_TREE_HITCNT_EN
    , .hit_cnt(hc[0])
`endif
  );

  pipelined_nand_nor_tree #(.WIDTH(5), .PIPE(1)) u_w5 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv[1]), .mode(md[1]), .a(a5),
    .out_valid(ov[1]), .f(fo[1])
`ifdef NAND_NOR_TREE_HITCNT_EN
    , .hit_cnt(hc[1])
`endif
  );

  pipelined_nand_nor_tree #(.WIDTH(64), .PIPE(0)) u_w64 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv[2]), .mode(md[2]), .a(a64),
    .out_valid(ov[2]), .f(fo[2])
`ifdef NAND_NOR_TREE_HITCNT_EN
    , .hit_cnt(hc[2])
`endif
  );

  typedef struct {
    logic f;
    int   due;
  } exp_t;

  exp_t          q [ND][$];
  int            adv = 0;
  logic [ND-1:0] eov = '0;
  logic [ND-1:0] ef  = '0;
  int            ehc [ND];
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int wid_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 5 : 64;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 2) ? 1 : 3;
  endfunction

  function automatic logic [63:0] a_of(input int d);
    return (d == 0) ? {56'b0, a8} : (d == 1) ? {59'b0, a5} : a64;
  endfunction

  function automatic logic ref_red(input logic [63:0] v, input int w, input logic m);
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (m) return |(v & mask);
    return &(v | ~mask);
  endfunction

  // Scoreboard: accepted samples are queued with the advance edge they must emerge on.
  always @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < ND; d++) begin
        q[d].delete();
        eov[d] = 1'b0;
        ef[d]  = 1'b0;
        ehc[d] = 0;
      end
    end else if (en) begin
      for (int d = 0; d < ND; d++) begin
        exp_t e;
        if (iv[d]) begin
          e.f   = ref_red(a_of(d), wid_of(d), md[d]);
          e.due = adv + lat_of(d) - 1;
          q[d].push_back(e);
        end
        if (q[d].size() > 0 && q[d][0].due == adv) begin
          e      = q[d].pop_front();
          eov[d] = 1'b1;
          ef[d]  = e.f;
          if (e.f && ehc[d] < 65535) ehc[d]++;
        end else begin
          eov[d] = 1'b0;
        end
      end
      adv++;
    end
  end

  // Compare every output on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("out_valid[%0d] adv=%0d", d, adv), {63'b0, ov[d]}, {63'b0, eov[d]});
      chk($sformatf("f[%0d] adv=%0d", d, adv), {63'b0, fo[d]}, {63'b0, ef[d]});
`ifdef NAND_NOR_TREE_HITCNT_EN
      chk($sformatf("hit_cnt[%0d]", d), {48'b0, hc[d]}, 64'(ehc[d]));
`endif
    end
  end

  task automatic idle(input int n);
    iv = '0;
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] s8a [8];
  logic [7:0] s8m;

  initial begin
    rst = 1'b1; en = 1'b1; iv = '0; md = '0; a8 = '0; a5 = '0; a64 = '0;
    s8a = '{8'hFF, 8'hFE, 8'h00, 8'h80, 8'h01, 8'h01, 8'h01, 8'h01};
    s8m = 8'b1010_1100;  // bit i = mode of sample i: 0,0,1,1,0,1,0,1
    repeat (3) @(negedge clk);
    chk("reset out_valid", {61'b0, ov}, 64'd0);
    chk("reset f", {61'b0, fo}, 64'd0);
    rst = 1'b0;

    // Directed samples, back to back, all three trees in parallel.
    for (int i = 0; i < 8; i++) begin
      a8 = s8a[i]; md[0] = s8m[i]; iv[0] = 1'b1;
      iv[1] = (i < 3);
      case (i)
        0: begin a5 = 5'h1F; md[1] = 1'b0; end
        1: begin a5 = 5'h0F; md[1] = 1'b0; end
        default: begin a5 = 5'h10; md[1] = 1'b1; end
      endcase
      iv[2] = (i < 2);
      md[2] = 1'b0;
      a64 = (i == 0) ? '1 : ~(64'd1 << 37);
      @(negedge clk);
    end
    idle(5);

    // Random traffic with random stalls and bubbles.
    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(0, 4) != 0);
      iv = 3'($urandom);
      md = 3'($urandom);
      case ($urandom_range(0, 3))
        0: begin a8 = '1; a5 = '1; a64 = '1; end
        1: begin a8 = '0; a5 = '0; a64 = '0; end
        default: begin a8 = 8'($urandom); a5 = 5'($urandom); a64 = {$urandom, $urandom}; end
      endcase
      @(negedge clk);
    end
    en = 1'b1;
    idle(5);

    // Stall: three samples issued, en low for four cycles with junk inputs.
    for (int i = 0; i < 3; i++) begin
      iv = '1; md = 3'(i); a8 = 8'hFF; a5 = 5'h1F; a64 = '1;
      if (i == 1) begin a8 = 8'h10; a5 = 5'h02; a64 = 64'h4; end
      @(negedge clk);
    end
    en = 1'b0; iv = '1; md = '0; a8 = 8'h00; a5 = 5'h00; a64 = '0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    idle(5);

    // Reset with two samples in flight; reset wins over en=0.
    iv = '1; md = '0; a8 = 8'hFF; a5 = 5'h1F; a64 = '1;
    repeat (2) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("rst flush out_valid", {61'b0, ov}, 64'd0);
    chk("rst flush f", {61'b0, fo}, 64'd0);
    rst = 1'b0; en = 1'b1;
    idle(4);
    iv = '1; md = '1; a8 = 8'h04; a5 = 5'h08; a64 = 64'h1;
    @(negedge clk);
    idle(5);

`ifdef NAND_NOR_TREE_HITCNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      iv = 3'b001; md = '0; a8 = (i < 5) ? 8'hFF : 8'hFE;
      @(negedge clk);
    end
    idle(5);
    chk("hit_cnt five hits", {48'b0, hc[0]}, 64'd5);
    iv = 3'b001; md = '0; a8 = 8'hFF;
    repeat (65540) @(negedge clk);
    idle(5);
    chk("hit_cnt saturated", {48'b0, hc[0]}, 64'hFFFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("hit_cnt cleared", {48'b0, hc[0]}, 64'd0);
`endif

    for (int d = 0; d < ND; d++) begin
      chk($sformatf("scoreboard drained[%0d]", d), 64'(q[d].size()), 64'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
